fetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue between the I-cache/memory interface and the decoder. It keeps fetching sequentially while the decoder stalls, holds fetch on unresolved jumps, and flushes and redirects on branch mispredict. It replaces the single-slot fetch stage and sits between the icache/mem controller and the decoder.

---
 rtl/fetch_queue_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_queue.sv | 173 +++++++++++++++++
 tb/tb_fetch_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : fetch_queue_pkg                                    |
// | Description : Shared bus widths, opcode constants, fetch FSM     |
// |               states and J-immediate helper for fetch_queue.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package fetch_queue_pkg;

  localparam int c_inst_w = 32;   // instruction bus width
  localparam int c_addr_w = 32;   // instruction address bus width

  localparam logic [c_addr_w-1:0] c_pc_step   = 32'd4;  // sequential PC increment
  localparam logic [c_addr_w-1:0] c_addr_free = 32'h0;  // idle address value
  localparam logic [c_inst_w-1:0] c_data_free = 32'h0;  // idle data value
  localparam logic [6:0]          c_op_jal    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,   // just out of reset
    ST_WORK   = 2'd1,   // requesting / awaiting fetch data
    ST_WAIT_J = 2'd2    // jump fetched, target not yet resolved
  } fetch_state_t;

  // Sign-extended J-type offset from instruction bits [31:12].
  function automatic logic [c_addr_w-1:0] jal_offset(input logic [19:0] f);
    return {{11{f[19]}}, f[19], f[7:0], f[8], f[18:9], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fetch_fifo                                         |
// | Description : Generic synchronous FIFO with push/pop/flush,      |
// |               occupancy count and combinational head data.       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_full;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_count == '0);
  assign w_full    = (r_count == (c_ptr_w+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign w_do_push = push & (~w_full | w_do_pop);
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

  // A push into a full FIFO without a freeing pop would lose an entry.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && w_full && !pop && !flush));

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fetch_queue                                        |
// | Description : Instruction-fetch front end with a DEPTH-entry     |
// |               prefetch queue, jump hold (WAIT_J) and mispredict  |
// |               flush/redirect.                                    |
// |               Optional macro FETCH_JAL_PREDECODE_EN: redirect    |
// |               on JAL immediately instead of waiting for enJump.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                   DEPTH    = 4,
  parameter logic [c_addr_w-1:0]  RESET_PC = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  output logic                 DecEn,
  output logic [c_addr_w-1:0]  DecPC,
  output logic [c_inst_w-1:0]  DecInst,
  output logic                 instEn,
  output logic [c_addr_w-1:0]  instAddr,
  input  logic                 hit,
  input  logic [c_inst_w-1:0]  cacheInst,
  input  logic                 memInstOutEn,
  input  logic [c_inst_w-1:0]  memInst,
  input  logic                 enJump,
  input  logic [c_addr_w-1:0]  JumpAddr,
  input  logic                 misTaken,
  input  logic [c_addr_w-1:0]  BranchAddr,
  output logic                 instDiscard
);

`ifdef FETCH_JAL_PREDECODE_EN
  localparam bit c_jal_predecode = 1'b1;
`else
  localparam bit c_jal_predecode = 1'b0;
`endif

  localparam int c_cnt_w = $clog2(DEPTH) + 1;
  localparam int c_ent_w = c_addr_w + c_inst_w;

  fetch_state_t          r_state;
  fetch_state_t          w_state_nx;
  logic [c_addr_w-1:0]   r_inst_addr;
  logic [c_addr_w-1:0]   w_inst_addr_nx;
  logic                  r_inst_en;
  logic                  w_inst_en_nx;
  logic                  r_discard;
  logic                  w_discard_nx;
  logic [c_addr_w-1:0]   r_last_pc;
  logic [c_inst_w-1:0]   r_last_inst;

  logic                  w_outstanding;
  logic                  w_resp;
  logic [c_inst_w-1:0]   w_resp_inst;
  logic                  w_is_jump;
  logic                  w_is_jal;
  logic                  w_deq;
  logic                  w_room;
  logic [c_ent_w-1:0]    w_head;
  logic [c_cnt_w-1:0]    w_count;
  logic [c_cnt_w:0]      w_proj;
  logic                  w_empty;

  // A request is outstanding only while fetching with instEn raised.
  assign w_outstanding = (r_state == ST_WORK) & r_inst_en;
  // Responses in a mispredict cycle belong to the wrong path and are dropped.
  assign w_resp        = w_outstanding & (hit | memInstOutEn) & ~misTaken;
  assign w_resp_inst   = hit ? cacheInst : memInst;
  assign w_is_jump     = w_resp_inst[6] & w_resp_inst[2];
  assign w_is_jal      = c_jal_predecode & (w_resp_inst[6:0] == c_op_jal);

  assign w_deq         = ~w_empty & ~stall & ~misTaken;
  // Projected occupancy after this edge decides whether another request fits.
  assign w_proj        = {1'b0, w_count} + (c_cnt_w+1)'(w_resp) - (c_cnt_w+1)'(w_deq);
  assign w_room        = (w_proj < (c_cnt_w+1)'(DEPTH));

  fetch_fifo #(
    .WIDTH (c_ent_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_resp),
    .pop   (w_deq),
    .flush (misTaken),
    .din   ({r_inst_addr, w_resp_inst}),
    .dout  (w_head),
    .count (w_count),
    .empty (w_empty)
  );

  assign DecEn       = w_deq;
  assign DecPC       = w_empty ? r_last_pc   : w_head[c_ent_w-1:c_inst_w];
  assign DecInst     = w_empty ? r_last_inst : w_head[c_inst_w-1:0];
  assign instEn      = r_inst_en;
  assign instAddr    = r_inst_addr;
  assign instDiscard = r_discard;

  // Fetch control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FREE;
      r_inst_addr <= RESET_PC;
      r_inst_en   <= 1'b0;
      r_discard   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_inst_addr <= w_inst_addr_nx;
      r_inst_en   <= w_inst_en_nx;
      r_discard   <= w_discard_nx;
    end
  end

  // Remember the last head so decoder outputs hold while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_pc   <= c_addr_free;
      r_last_inst <= c_data_free;
    end else if (!w_empty) begin
      r_last_pc   <= w_head[c_ent_w-1:c_inst_w];
      r_last_inst <= w_head[c_inst_w-1:0];
    end
  end

  // Next-state, next fetch address and request/discard decisions.
  always_comb begin
    w_state_nx     = r_state;
    w_inst_addr_nx = r_inst_addr;
    w_inst_en_nx   = (r_state == ST_WORK) & w_room;
    w_discard_nx   = 1'b0;

    case (r_state)
      ST_FREE: begin
        w_state_nx = ST_WORK;
      end
      ST_WORK: begin
        if (w_resp) begin
          if (w_is_jump && !w_is_jal) begin
            w_state_nx   = ST_WAIT_J;
            w_inst_en_nx = 1'b0;
          end else if (w_is_jal) begin
            w_inst_addr_nx = r_inst_addr + jal_offset(w_resp_inst[31:12]);
          end else begin
            w_inst_addr_nx = r_inst_addr + c_pc_step;
          end
        end
      end
      ST_WAIT_J: begin
        if (enJump) begin
          w_inst_addr_nx = JumpAddr;
          w_state_nx     = ST_WORK;
        end
      end
      default: begin
        w_state_nx = ST_FREE;
      end
    endcase

    // Mispredict overrides everything except reset.
    if (misTaken) begin
      w_state_nx     = ST_WORK;
      w_inst_addr_nx = BranchAddr;
      w_inst_en_nx   = 1'b1;
      w_discard_nx   = w_outstanding & ~(hit | memInstOutEn);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                     |
// | Description : Randomised scoreboard bench for fetch_queue. The   |
// |               bench plays cache, memory and branch unit; a       |
// |               program-order model predicts decoder output.       |
// |               Honours FETCH_JAL_PREDECODE_EN when defined.       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_JAL_PREDECODE_EN
  localparam bit PREDECODE = 1'b1;
`else
  localparam bit PREDECODE = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic        hit = 1'b0, memInstOutEn = 1'b0, enJump = 1'b0, misTaken = 1'b0;
  logic [31:0] cacheInst = '0, memInst = '0, JumpAddr = '0, BranchAddr = '0;
  logic        DecEn, instEn, instDiscard;
  logic [31:0] DecPC, DecInst, instAddr;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .DecEn(DecEn), .DecPC(DecPC), .DecInst(DecInst),
    .instEn(instEn), .instAddr(instAddr),
    .hit(hit), .cacheInst(cacheInst),
    .memInstOutEn(memInstOutEn), .memInst(memInst),
    .enJump(enJump), .JumpAddr(JumpAddr),
    .misTaken(misTaken), .BranchAddr(BranchAddr),
    .instDiscard(instDiscard)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          idle  = 0;
  logic [63:0] exp_q[$];            // {pc, inst} the decoder must see, in order
  logic [63:0] last_shown = '0;     // what the decoder outputs hold when empty
  bit          pend_v = 1'b0;       // entry accepted this cycle, visible next
  logic [63:0] pend;
  bit          waiting = 1'b0;      // model: jump fetched, target unknown
  logic [31:0] model_pc = RESET_PC; // model: address of the next instruction
  bit          exp_disc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] j_offset(input logic [31:0] i);
    logic [31:0] imm;
    imm        = '0;
    imm[20]    = i[31];
    imm[19:12] = i[19:12];
    imm[11]    = i[20];
    imm[10:1]  = i[30:21];
    if (i[31]) imm[31:21] = '1;
    return imm;
  endfunction

  function automatic logic [31:0] gen_inst(input bit allow_jump);
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 99);
    if (allow_jump && k < 6)  return {r[31:7], 7'b1101111};   // JAL
    if (allow_jump && k < 12) return {r[31:7], 7'b1100111};   // JALR
    if (r[6] && r[2]) r[2] = 1'b0;
    return r;
  endfunction

  // Monitor: compare decoder outputs with the head of the expected stream.
  always @(negedge clk) begin
    bit exp_en;
    if (!rst) begin
      exp_en = (exp_q.size() > 0) && !stall && !misTaken;
      check("DecEn", 64'(DecEn), 64'(exp_en));
      if (exp_q.size() > 0) begin
        check("DecPC", 64'(DecPC), 64'(exp_q[0][63:32]));
        check("DecInst", 64'(DecInst), 64'(exp_q[0][31:0]));
        last_shown = exp_q[0];
        if (exp_en) void'(exp_q.pop_front());
      end else begin
        check("DecPC_hold", 64'(DecPC), 64'(last_shown[63:32]));
        check("DecInst_hold", 64'(DecInst), 64'(last_shown[31:0]));
      end
    end
  end

  // One clock of stimulus plus the fetch-side checks and model update.
  task automatic drive_cycle(input int stall_pct, input int hit_pct, input bit allow_jump,
                             input int mis_pct, output bit did_resp);
    logic [31:0] inst;
    bit          mis;
    did_resp = 1'b0;
    @(posedge clk); #1;
    if (pend_v) begin
      exp_q.push_back(pend);
      pend_v = 1'b0;
    end
    check("instDiscard", 64'(instDiscard), 64'(exp_disc));
    check("fetch_while_full", 64'(instEn && (exp_q.size() >= DEPTH)), 64'd0);
    if (waiting) check("instEn_in_wait_j", 64'(instEn), 64'd0);
    if (!instEn && !waiting && exp_q.size() < DEPTH) idle++;
    else idle = 0;
    if (idle > 4) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fetch_stuck: instEn=0 for %0d cycles, required 1", idle);
      idle = 0;
    end

    stall      = ($urandom_range(0, 99) < stall_pct);
    mis        = ($urandom_range(0, 99) < mis_pct);
    misTaken   = mis;
    BranchAddr = $urandom & 32'h0000_0FFC;
    JumpAddr   = $urandom & 32'h0000_0FFC;
    cacheInst  = gen_inst(allow_jump);
    memInst    = gen_inst(allow_jump);
    if (instEn) begin
      hit          = ($urandom_range(0, 99) < hit_pct);
      memInstOutEn = ($urandom_range(0, 99) < 25);
    end else begin
      hit          = ($urandom_range(0, 99) < 10);
      memInstOutEn = ($urandom_range(0, 99) < 10);
    end
    enJump = waiting ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);

    exp_disc = mis && instEn && !hit && !memInstOutEn;
    if (mis) begin
      if (exp_q.size() > 0) last_shown = exp_q[0];
      exp_q.delete();
      model_pc = BranchAddr;
      waiting  = 1'b0;
    end else if (instEn && (hit || memInstOutEn)) begin
      inst = hit ? cacheInst : memInst;
      check("instAddr", 64'(instAddr), 64'(model_pc));
      pend     = {model_pc, inst};
      pend_v   = 1'b1;
      did_resp = 1'b1;
      if (inst[6] && inst[2]) begin
        if (PREDECODE && inst[6:0] == 7'b1101111) model_pc = model_pc + j_offset(inst);
        else waiting = 1'b1;
      end else begin
        model_pc = model_pc + 32'd4;
      end
    end else if (waiting && enJump) begin
      model_pc = JumpAddr;
      waiting  = 1'b0;
    end
  endtask

  // Reset (with a simultaneous mispredict and hit that must be ignored).
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; misTaken = 1'b1; hit = 1'b1; memInstOutEn = 1'b0; enJump = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    misTaken = 1'b0; hit = 1'b0;
    check("rst_DecEn", 64'(DecEn), 64'd0);
    check("rst_instEn", 64'(instEn), 64'd0);
    check("rst_instAddr", 64'(instAddr), 64'(RESET_PC));
    check("rst_instDiscard", 64'(instDiscard), 64'd0);
    check("rst_DecPC", 64'(DecPC), 64'd0);
    check("rst_DecInst", 64'(DecInst), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    pend_v     = 1'b0;
    waiting    = 1'b0;
    model_pc   = RESET_PC;
    exp_disc   = 1'b0;
    last_shown = '0;
    idle       = 0;
  endtask

  initial begin
    bit r;
    int n_fill;
    do_reset();
    // Continuous hits, no stall: one instruction per cycle from RESET_PC.
    for (int i = 0; i < 14; i++) drive_cycle(0, 100, 1'b0, 0, r);

    // Stalled decoder: fetch must stop once DEPTH entries are queued.
    do_reset();
    n_fill = 0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(100, 100, 1'b0, 0, r);
      if (r) n_fill++;
    end
    check("fill_count", 64'(n_fill), 64'(DEPTH));
    check("full_instEn", 64'(instEn), 64'd0);
    check("resume_addr", 64'(instAddr), 64'(RESET_PC + 32'(4 * DEPTH)));
    for (int i = 0; i < 8; i++) drive_cycle(0, 100, 1'b0, 0, r);

    // Randomised traffic: stalls, jumps, memory/cache mix, mispredicts.
    for (int i = 0; i < 3000; i++) drive_cycle(30, 45, 1'b1, 3, r);
    do_reset();
    for (int i = 0; i < 1500; i++) drive_cycle(50, 60, 1'b1, 5, r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
